decoder_n_seq: RTL and testbench
================================

// Module: decoder_n_seq
// PURPOSE
//   Parametrised N-to-2^N decoder with registered output, valid/ready handshake
//   and multi-beat modes. One accepted command produces one code word (DECODE,
//   THERMO) or a walking one-hot burst (SCAN_UP, SCAN_DOWN). Used as a select /
//   strobe generator between a command source and register-bank or mux consumers.
// PARAMETERS
//   N        3   select width; output width W = 2**N (derived localparam)
//   OUT_INV  0   1 = every output code bit inverted (active-low strobes)
// PORTS
//   clk        in   1    rising-edge clock
//   reset      in   1    synchronous, active-high
//   in_valid   in   1    command valid
//   in_ready   out  1    command accepted when in_valid && in_ready
//   sel        in   N    select index, sampled at acceptance
//   mode       in   2    00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 THERMO; sampled at acceptance
//   out_valid  out  1    code word valid
//   out_ready  in   1    consumer accepts word when out_valid && out_ready
//   code       out  W    output word (after OUT_INV)
//   index      out  N    index of current word (one-hot position / thermo top bit)
//   last       out  1    high on final word of the command
// BEHAVIOUR
// - FSM states: IDLE, EMIT. Reset (synchronous, any state, mid-burst included):
//   state=IDLE, out_valid=0, last=0, index=0, code=0 (all ones if OUT_INV=1);
//   any command in flight is dropped, no further words.
// - in_ready = (state==IDLE). No command accepted while in EMIT.
// - IDLE: on acceptance, latch mode, set index=sel, go EMIT; out_valid=1 the
//   next cycle (latency 1 cycle acceptance -> first word).
// - Raw code for index i: DECODE/SCAN_*: bit i only set. THERMO: bits [i:0] set.
//   code = OUT_INV ? ~raw : raw. Exactly W bits, no truncation.
// - last: DECODE, THERMO: always 1 (single word). SCAN_UP: index==W-1.
//   SCAN_DOWN: index==0. So SCAN_UP from sel emits W-sel words, SCAN_DOWN sel+1.
// - EMIT, out_valid && !out_ready: code, index, last, out_valid held stable.
// - EMIT, handshake with last=1: go IDLE, out_valid=0 next cycle.
// - EMIT, handshake with last=0: index +1 (SCAN_UP) or -1 (SCAN_DOWN) next cycle,
//   out_valid stays 1; no wrap-around ever occurs (last terminates first).
// - Throughput: one word per cycle within a burst; min 1 idle cycle between
//   commands (in_ready high only in IDLE), so back-to-back commands need 2 cycles.
// - In IDLE out_valid=0; code/index/last hold last values (don't-care for consumer).
// - mode/sel changes while in EMIT have no effect.
// TESTING (N=3, OUT_INV=0 unless stated)
// 1 reset; check in_ready=1, out_valid=0, code=8'h00; DECODE sel=5, out_ready=1 ->
//   next cycle code=8'h20, index=5, last=1; following cycle out_valid=0.
// 2 SCAN_UP sel=5, out_ready=1 -> codes 8'h20,8'h40,8'h80 on consecutive cycles,
//   last only on 8'h80; in_ready=0 throughout, 1 after.
// 3 SCAN_DOWN sel=2, out_ready toggling 1,0,1,0,1 -> codes 8'h04,8'h02,8'h01,
//   each held stable across stall cycles; last on 8'h01.
// 4 THERMO sel=3 -> code=8'h0F; sel=7 -> 8'hFF; sel=0 -> 8'h01; with OUT_INV=1
//   sel=3 -> 8'hF0 and reset value 8'hFF.
// 5 SCAN_UP sel=0, assert reset after 3rd word while out_valid high -> next
//   cycle out_valid=0, code=0, in_ready=1; no further words.
// 6 in_valid held high with DECODE sel=1 then sel=6 -> accepted 2 cycles apart,
//   codes 8'h02 then 8'h40; sel change during EMIT ignored.

Source files
------------

// File: rtl/decoder_n_seq_if.sv
// Command/word handshake bundle for decoder_n_seq: command side (in_*, sel, mode)
// and code-word side (out_*, code, index, last).
interface decoder_n_seq_if #(
    parameter int N = 3
);
    localparam int W = 2 ** N;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] sel;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] code;
    logic [N-1:0] index;
    logic         last;

    modport master (
        output in_valid, sel, mode, out_ready,
        input  in_ready, out_valid, code, index, last
    );

    modport slave (
        input  in_valid, sel, mode, out_ready,
        output in_ready, out_valid, code, index, last
    );
endinterface

// File: rtl/decoder_n_seq.sv
// N-to-2^N decoder with registered output word, valid/ready handshake and
// walking one-hot scan bursts (SCAN_UP / SCAN_DOWN) alongside DECODE / THERMO.
module decoder_n_seq #(
    parameter int N       = 3,
    parameter bit OUT_INV = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    decoder_n_seq_if.slave   bus
);
    localparam int W = 2 ** N;

    localparam logic [1:0] M_DECODE    = 2'b00;
    localparam logic [1:0] M_SCAN_UP   = 2'b01;
    localparam logic [1:0] M_SCAN_DOWN = 2'b10;
    localparam logic [1:0] M_THERMO    = 2'b11;

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [N-1:0]   index_q, index_d;
    logic [W-1:0]   code_q, code_d;
    logic           last_q, last_d;

    function automatic logic [W-1:0] make_code(input logic [N-1:0] i, input logic [1:0] m);
        logic [W-1:0] raw;
        raw = '0;
        for (int b = 0; b < W; b++) begin
            raw[b] = (m == M_THERMO) ? (b <= int'(i)) : (b == int'(i));
        end
        return OUT_INV ? ~raw : raw;
    endfunction

    function automatic logic make_last(input logic [N-1:0] i, input logic [1:0] m);
        case (m)
            M_SCAN_UP:   return i == N'(W - 1);
            M_SCAN_DOWN: return i == '0;
            default:     return 1'b1;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        index_d = index_q;
        code_d  = code_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = EMIT;
                    mode_d  = bus.mode;
                    index_d = bus.sel;
                    code_d  = make_code(bus.sel, bus.mode);
                    last_d  = make_last(bus.sel, bus.mode);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        // last terminates a scan before the index could wrap
                        index_d = (mode_q == M_SCAN_UP) ? index_q + N'(1) : index_q - N'(1);
                        code_d  = make_code(index_d, mode_q);
                        last_d  = make_last(index_d, mode_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= M_DECODE;
            index_q <= '0;
            code_q  <= OUT_INV ? '1 : '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            index_q <= index_d;
            code_q  <= code_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.code      = code_q;
    assign bus.index     = index_q;
    assign bus.last      = last_q;
endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed bench for decoder_n_seq: single-word vector table plus scan, stall,
// reset-abort, back-to-back and inverted-output sequences.
module tb_decoder_n_seq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decoder_n_seq_if #(.N(3)) bus0 ();
    decoder_n_seq_if #(.N(3)) bus1 ();

    decoder_n_seq #(.N(3), .OUT_INV(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    decoder_n_seq #(.N(3), .OUT_INV(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sel;
        logic [7:0] code;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs [6];
    logic [7:0] exp_seq [5];

    initial begin
        vecs[0] = '{2'b00, 3'd5, 8'h20};
        vecs[1] = '{2'b11, 3'd3, 8'h0F};
        vecs[2] = '{2'b11, 3'd7, 8'hFF};
        vecs[3] = '{2'b11, 3'd0, 8'h01};
        vecs[4] = '{2'b00, 3'd0, 8'h01};
        vecs[5] = '{2'b00, 3'd7, 8'h80};

        reset = 1'b1;
        bus0.in_valid = 0; bus0.sel = 0; bus0.mode = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.sel = 0; bus1.mode = 0; bus1.out_ready = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst in_ready", bus0.in_ready, 1);
        chk("rst out_valid", bus0.out_valid, 0);
        chk("rst code", bus0.code, 8'h00);
        chk("rst index", bus0.index, 0);
        chk("rst last", bus0.last, 0);
        chk("rst code inv", bus1.code, 8'hFF);

        // single-word commands
        for (int k = 0; k < 6; k++) begin
            bus0.in_valid = 1; bus0.mode = vecs[k].mode; bus0.sel = vecs[k].sel;
            chk("vec in_ready", bus0.in_ready, 1);
            @(negedge clk);
            bus0.in_valid = 0;
            chk("vec out_valid", bus0.out_valid, 1);
            chk("vec code", bus0.code, vecs[k].code);
            chk("vec index", bus0.index, vecs[k].sel);
            chk("vec last", bus0.last, 1);
            chk("vec in_ready busy", bus0.in_ready, 0);
            @(negedge clk);
            chk("vec done", bus0.out_valid, 0);
        end

        // SCAN_UP from 5
        bus0.in_valid = 1; bus0.mode = 2'b01; bus0.sel = 3'd5;
        @(negedge clk);
        bus0.in_valid = 0;
        exp_seq[0] = 8'h20; exp_seq[1] = 8'h40; exp_seq[2] = 8'h80;
        for (int k = 0; k < 3; k++) begin
            chk("up valid", bus0.out_valid, 1);
            chk("up code", bus0.code, exp_seq[k]);
            chk("up index", bus0.index, 5 + k);
            chk("up last", bus0.last, (k == 2) ? 1 : 0);
            chk("up in_ready", bus0.in_ready, 0);
            @(negedge clk);
        end
        chk("up end valid", bus0.out_valid, 0);
        chk("up end in_ready", bus0.in_ready, 1);

        // SCAN_DOWN from 2 with stalls: out_ready 1,0,1,0,1
        bus0.in_valid = 1; bus0.mode = 2'b10; bus0.sel = 3'd2;
        @(negedge clk);
        bus0.in_valid = 0;
        exp_seq[0] = 8'h04; exp_seq[1] = 8'h02; exp_seq[2] = 8'h02;
        exp_seq[3] = 8'h01; exp_seq[4] = 8'h01;
        for (int k = 0; k < 5; k++) begin
            chk("dn valid", bus0.out_valid, 1);
            chk("dn code", bus0.code, exp_seq[k]);
            chk("dn last", bus0.last, (k >= 3) ? 1 : 0);
            bus0.out_ready = (k % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("dn end valid", bus0.out_valid, 0);
        bus0.out_ready = 1;

        // SCAN_UP from 0, reset after third word
        bus0.in_valid = 1; bus0.mode = 2'b01; bus0.sel = 3'd0;
        @(negedge clk);
        bus0.in_valid = 0;
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
        for (int k = 0; k < 3; k++) begin
            chk("abort code", bus0.code, exp_seq[k]);
            chk("abort valid", bus0.out_valid, 1);
            if (k < 2) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort rst valid", bus0.out_valid, 0);
        chk("abort rst code", bus0.code, 8'h00);
        chk("abort rst in_ready", bus0.in_ready, 1);
        chk("abort rst last", bus0.last, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort no words", bus0.out_valid, 0);
        end

        // in_valid held high; sel change during EMIT ignored
        bus0.in_valid = 1; bus0.mode = 2'b00; bus0.sel = 3'd1;
        @(negedge clk);
        chk("b2b first valid", bus0.out_valid, 1);
        chk("b2b first code", bus0.code, 8'h02);
        bus0.sel = 3'd6;
        @(negedge clk);
        chk("b2b gap valid", bus0.out_valid, 0);
        chk("b2b gap in_ready", bus0.in_ready, 1);
        chk("b2b gap code hold", bus0.code, 8'h02);
        @(negedge clk);
        bus0.in_valid = 0;
        chk("b2b second valid", bus0.out_valid, 1);
        chk("b2b second code", bus0.code, 8'h40);
        chk("b2b second index", bus0.index, 6);
        @(negedge clk);

        // inverted outputs
        bus1.in_valid = 1; bus1.mode = 2'b11; bus1.sel = 3'd3;
        @(negedge clk);
        bus1.in_valid = 0;
        chk("inv thermo valid", bus1.out_valid, 1);
        chk("inv thermo code", bus1.code, 8'hF0);
        bus1.in_valid = 1; bus1.mode = 2'b00; bus1.sel = 3'd2;
        @(negedge clk);
        chk("inv idle", bus1.out_valid, 0);
        @(negedge clk);
        bus1.in_valid = 0;
        chk("inv decode code", bus1.code, 8'hFB);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
